// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
// Holds the fetch FSM state encoding and the end-of-program marker word.
package inst_fetch_pkg;

  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  localparam logic [INST_W-1:0] END_MARKER = 32'h0000_0000;

  function automatic logic is_end_marker(input logic [INST_W-1:0] word);
    return (word == END_MARKER);
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: drives the word address of a registered-output ROM and
// presents each returned word with its byte PC; stops at the end marker.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       start_pc,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  output logic              done
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              at_end;
  logic              unused_low_bits;

  // Byte addresses are word aligned; the two low bits never reach the ROM.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
    return ADDR_W'(byte_addr[31:2]);
  endfunction

  assign unused_low_bits = ^{start_pc[1:0], redirect_pc[1:0]};
  assign at_end          = is_end_marker(rom_inst);

  // rom_addr is what the ROM latches this edge, so pc_q always names the
  // word currently on rom_inst; holding it replays that word (stall).
  always_comb begin
    state_d  = state_q;
    rom_addr = pc_q;
    if_valid = 1'b0;
    done     = 1'b0;
    if (rst) begin
      state_d  = ST_IDLE;
      rom_addr = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rom_addr = word_addr(start_pc);
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          if_valid = !at_end;
          if (redirect) begin
            rom_addr = word_addr(redirect_pc);
          end else if (stall) begin
            rom_addr = pc_q;
          end else if (at_end) begin
            rom_addr = pc_q;
            state_d  = ST_DONE;
          end else begin
            rom_addr = pc_q + ADDR_W'(1);
          end
        end
        ST_DONE: begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= rom_addr;
    end
  end

  assign if_pc   = rst ? 32'h0 : 32'({pc_q, 2'b00});
  assign if_inst = rom_inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch with a behavioural registered ROM.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] start_pc;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [29:0] rom_addr;
  logic [31:0] rom_inst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        done;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        dn;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] mem [0:63];

  inst_fetch #(.ADDR_W(30)) dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .rom_addr(rom_addr), .rom_inst(rom_inst), .if_valid(if_valid),
    .if_pc(if_pc), .if_inst(if_inst), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_inst <= mem[rom_addr[5:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if_valid || done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got pc=%h inst=%h done=%b expected nothing", if_pc, if_inst, done);
      end else begin
        e = sb.pop_front();
        chk("if_valid", {31'b0, if_valid}, {31'b0, e.vld});
        chk("if_pc",    if_pc,             e.pc);
        chk("if_inst",  if_inst,           e.inst);
        chk("done",     {31'b0, done},     {31'b0, e.dn});
      end
    end
  end

  task automatic push(input logic vld, input logic [31:0] pc, input logic [31:0] inst, input logic dn);
    exp_t e;
    e.vld = vld; e.pc = pc; e.inst = inst; e.dn = dn;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic st, input logic [31:0] spc, input logic stl,
                     input logic rd, input logic [31:0] rpc);
    start = st; start_pc = spc; stall = stl; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    #1;
    start = 1'b0; stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"},    {31'b0, if_valid}, 32'h0);
    chk({nm, "_done"},     {31'b0, done},     32'h0);
    chk({nm, "_rom_addr"}, {2'b0, rom_addr},  32'h0);
    chk({nm, "_if_pc"},    if_pc,             32'h0);
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    #1;
    rst = 1'b1; stall = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_mid_if_pc", if_pc, 32'h0);
    repeat (3) begin
      chk("rst_mid_done", {31'b0, done}, 32'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'h3c1d1000;
    mem[1]  = 32'h37bd4000;
    mem[2]  = 32'h3c081780;
    mem[3]  = 32'h24080001;
    mem[4]  = 32'h8d090000;
    mem[29] = 32'hac2a0000;
    mem[30] = 32'h00000000;

    rst = 1'b1; start = 1'b0; start_pc = '0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    repeat (2) begin
      @(negedge clk);
      chk_idle("reset");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_idle("idle");
    end
    @(posedge clk);
    #1;

    // Sequential fetch, start ignored in RUN, stall hold, redirect beats stall
    push(1, 32'h0, 32'h3c1d1000, 0); cyc(1, 32'h0, 0, 0, 0);
    push(1, 32'h4, 32'h37bd4000, 0); cyc(0, 0, 0, 0, 0);
    push(1, 32'h8, 32'h3c081780, 0); cyc(1, 32'h40, 0, 0, 0);
    push(1, 32'h8, 32'h3c081780, 0); cyc(0, 0, 1, 0, 0);
    push(1, 32'h8, 32'h3c081780, 0); cyc(0, 0, 1, 0, 0);
    push(1, 32'hC, 32'h24080001, 0); cyc(0, 0, 0, 0, 0);
    push(1, 32'h74, 32'hac2a0000, 0); cyc(0, 0, 1, 1, 32'h74);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("marker_valid", {31'b0, if_valid}, 32'h0);
    chk("marker_done", {31'b0, done}, 32'h0);
    chk("marker_rom_addr", {2'b0, rom_addr}, 32'd30);
    push(0, 32'h78, 32'h0, 1); cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("after_done_valid", {31'b0, if_valid}, 32'h0);
    chk("after_done_done", {31'b0, done}, 32'h0);

    // Restart from IDLE, then reset mid-run with stall
    push(1, 32'h10, 32'h8d090000, 0); cyc(1, 32'h10, 0, 0, 0);
    push(1, 32'h14, 32'h10000005, 0); cyc(0, 0, 0, 0, 0);
    reset_mid_run();

    // Marker under stall is ignored; redirect on marker cancels done; wrap
    push(1, 32'h74, 32'hac2a0000, 0); cyc(1, 32'h74, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("stalled_marker_valid", {31'b0, if_valid}, 32'h0);
    chk("stalled_marker_done", {31'b0, done}, 32'h0);
    push(1, 32'h4, 32'h37bd4000, 0); cyc(0, 0, 0, 1, 32'h4);
    push(1, 32'h8, 32'h3c081780, 0); cyc(0, 0, 0, 0, 0);
    push(1, 32'hFFFFFFFC, 32'h1000003F, 0); cyc(0, 0, 0, 1, 32'hFFFFFFFF);
    push(1, 32'h0, 32'h3c1d1000, 0); cyc(0, 0, 0, 0, 0);
    push(1, 32'h4, 32'h37bd4000, 0); cyc(0, 0, 0, 0, 0);
    reset_mid_run();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, the word-address width presented to the instruction ROM.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port start, input, 1, one-cycle pulse that begins fetching at start_pc.
REQ-005 SHALL have port start_pc, input, 32, byte address of the first command word; bits [1:0] ignored.
REQ-006 SHALL have port stall, input, 1, downstream not accepting; hold the current word.
REQ-007 SHALL have port redirect, input, 1, one-cycle jump request.
REQ-008 SHALL have port redirect_pc, input, 32, byte jump target; bits [1:0] ignored.
REQ-009 SHALL have port rom_addr, output, ADDR_W, word address to the ROM; the ROM registers it and returns data next cycle.
REQ-010 SHALL have port rom_inst, input, 32, ROM data for the address latched on the previous edge.
REQ-011 SHALL have port if_valid, output, 1, if_inst/if_pc hold a live word.
REQ-012 SHALL have port if_pc, output, 32, byte address of if_inst.
REQ-013 SHALL have port if_inst, output, 32, the fetched word, equal to rom_inst.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when the end marker is reached.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE, plus a registered word pointer pc_q equal to the address the ROM currently holds.
REQ-016 In IDLE, rom_addr SHALL equal start_pc[31:2] when start=1, else pc_q; if_valid=0; start moves to RUN.
REQ-017 In RUN, rom_addr SHALL be: redirect_pc[31:2] if redirect; else pc_q if stall; else pc_q+1. On every edge, pc_q SHALL load rom_addr.
REQ-018 if_valid SHALL be 1 in RUN unless the end marker is present; if_pc = {pc_q,2'b00}.
REQ-019 Latency SHALL be one cycle: start or redirect in cycle n gives the target word valid in cycle n+1, with no bubble.
REQ-020 Under stall, rom_addr SHALL re-present pc_q, so if_inst/if_pc stay constant for every stalled cycle.
REQ-021 Redirect SHALL take priority over stall in the same cycle.
REQ-022 start SHALL be ignored in RUN and DONE.
REQ-023 rom_inst==32'h00000000 in RUN is the end marker. It SHALL force if_valid=0 and be ignored if stall=1. With stall=0 it SHALL pulse done for one cycle, go to DONE and hold pc_q. Redirect in that same cycle wins: no done, stay in RUN.
REQ-024 The pc_q increment SHALL wrap modulo 2^ADDR_W without error.
REQ-025 DONE SHALL last one cycle (done=1, if_valid=0), then go to IDLE.

Reset
REQ-026 While rst=1: state SHALL become IDLE and pc_q=0, with rom_addr=0, if_valid=0, done=0, if_pc=0.
REQ-027 rst SHALL override start, redirect and stall in the same cycle.
REQ-028 Reset in RUN SHALL drop if_valid on the next cycle; no done pulse.

Structure
REQ-029 State encodings and the END_MARKER constant (32'h0) SHALL live in the shared GP package.
REQ-030 SHALL be one flat module; the ROM is instantiated by the parent, not here.

Verification
REQ-031 rst for 2 cycles, then idle -> if_valid=0, rom_addr=0, done=0 on every cycle.
REQ-032 start with start_pc=0 and a ROM holding 3c1d1000, 37bd4000, 3c081780 -> next cycle if_pc=0/if_inst=3c1d1000, then if_pc=4/37bd4000, then 8/3c081780.
REQ-033 stall=1 for 2 cycles while if_pc=8 -> if_inst=3c081780 for 3 cycles, then if_pc=C.
REQ-034 redirect with redirect_pc=0x74 and stall=1 in the same cycle -> next cycle if_pc=0x74; if_inst=ac2a0000.
REQ-035 after 0x74, word 0x78 reads 0 -> if_valid=0 and done=1 for one cycle, next cycle IDLE; a later start with start_pc=0x10 -> if_pc=0x10 one cycle later.
REQ-036 rst asserted mid-RUN with stall=1 -> next cycle if_valid=0, if_pc=0, done never asserted.
